axi_master_rd: RTL and testbench

//  AXI4 read-channel master: turns one local read request (addr, beat count) into one AR burst,

---
 rtl/axi_master_rd.sv | 179 +++++++++++++++++
 tb/tb_axi_master_rd.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rd.sv
// axi_master_rd: AXI4 read-channel master.
// Turns one local read request (lcl_iaddr, lcl_inum) into a single INCR AR burst,
// buffers returned R beats in a show-ahead FIFO and streams them to the local
// sink under lcl_ordy backpressure. One burst outstanding at a time.
// Ports:
//   clk, rst_n, clear          clock, async active-low reset, sticky-error clear
//   i_snap_context             context word; LSBs become ARUSER
//   m_axi_ar*                  AR channel (registered address/len/user/valid)
//   m_axi_r*                   R channel (rready registered)
//   lcl_istart/iaddr/inum      request strobe, start address, beat count (0 = 256)
//   lcl_ibusy                  burst in progress
//   lcl_ordy/dv/dout/olast     local data stream, FIFO head
//   status, error              {full, empty, len_err, busy, rd_error}, {early, late, rd_error}
module axi_master_rd #(
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ARUSER_WIDTH = 8,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [31:0]             i_snap_context,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    lcl_ibusy,
  input  logic                    lcl_istart,
  input  logic [ADDR_WIDTH-1:0]   lcl_iaddr,
  input  logic [7:0]              lcl_inum,
  input  logic                    lcl_ordy,
  output logic                    lcl_dv,
  output logic [DATA_WIDTH-1:0]   lcl_dout,
  output logic                    lcl_olast,
  output logic [5:0]              status,
  output logic [3:0]              error
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t               state, state_d;
  logic [7:0]           beat_cnt;
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_d;
  logic                 full_d, rready_d;
  logic                 fifo_full, fifo_empty;
  logic                 rlast_early, rlast_late;
  logic [1:0]           rd_error;
  logic [DATA_WIDTH:0]  mem [DEPTH];

  logic r_hs, data_hs, beat_last, push, pop;
  logic unused_ok;

  // Fixed AR attributes
  assign m_axi_arid     = '0;
  assign m_axi_arsize   = 3'd3;
  assign m_axi_arburst  = 2'd1;
  assign m_axi_arcache  = 4'd3;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;

  assign unused_ok = ^{m_axi_rid, i_snap_context[31:ARUSER_WIDTH]};

  // Handshakes; a beat ends the burst on RLAST or when the requested count is reached
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign data_hs   = r_hs & (state == S_DATA);
  assign beat_last = m_axi_rlast | (beat_cnt == m_axi_arlen);
  assign push      = data_hs;
  assign pop       = lcl_dv & lcl_ordy;

  // FIFO flags and show-ahead head
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign lcl_dv     = ~fifo_empty;
  assign lcl_dout   = mem[rd_ptr][DATA_WIDTH-1:0];
  assign lcl_olast  = lcl_dv & mem[rd_ptr][DATA_WIDTH];

  assign status = {fifo_full, fifo_empty, rlast_early | rlast_late, lcl_ibusy, rd_error};
  assign error  = {rlast_early, rlast_late, rd_error};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state, next FIFO occupancy and next RREADY
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (lcl_istart) state_d = S_ADDR;
      S_ADDR:  if (m_axi_arvalid && m_axi_arready) state_d = S_DATA;
      S_DATA:  if (data_hs && beat_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && lcl_olast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    count_d  = count + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    // Registered so it matches the current state/full while holding 0 in reset
    rready_d = ((state_d == S_DATA) & ~full_d) | (state_d == S_IDLE) | (state_d == S_DRAIN);
  end

  // AR channel, counters, FIFO pointers and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_aruser  <= '0;
      m_axi_rready  <= 1'b0;
      lcl_ibusy     <= 1'b0;
      beat_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rlast_early   <= 1'b0;
      rlast_late    <= 1'b0;
      rd_error      <= 2'b00;
    end else begin
      if (state == S_IDLE && lcl_istart) begin
        m_axi_araddr  <= lcl_iaddr;
        m_axi_arlen   <= lcl_inum - 8'd1;
        m_axi_aruser  <= i_snap_context[ARUSER_WIDTH-1:0];
        m_axi_arvalid <= 1'b1;
      end else if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
      end

      m_axi_rready <= rready_d;
      lcl_ibusy    <= (state_d != S_IDLE);

      if (data_hs) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;

      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count_d;

      if (clear) begin
        rlast_early <= 1'b0;
        rlast_late  <= 1'b0;
        rd_error    <= 2'b00;
      end else begin
        if (r_hs && m_axi_rresp != 2'b00) rd_error <= m_axi_rresp;
        // Beats outside DATA are protocol excess and are dropped
        if (r_hs && state != S_DATA) rlast_late <= 1'b1;
        if (data_hs && m_axi_rlast && beat_cnt != m_axi_arlen) rlast_early <= 1'b1;
        if (data_hs && !m_axi_rlast && beat_cnt == m_axi_arlen) rlast_late <= 1'b1;
      end
    end
  end

  // FIFO storage: {olast, data}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {beat_last, m_axi_rdata};
  end

endmodule

// File: tb/tb_axi_master_rd.sv
// tb_axi_master_rd: directed bench for axi_master_rd with a table of bursts
// and hand-written sequences for backpressure, busy-ignore and mid-burst reset.
module tb_axi_master_rd;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic [31:0] i_snap_context;
  logic [0:0]  m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_arlock;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic [3:0]  m_axi_arregion;
  logic [7:0]  m_axi_aruser;
  logic        m_axi_arvalid, m_axi_arready;
  logic [0:0]  m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        lcl_ibusy, lcl_istart;
  logic [63:0] lcl_iaddr;
  logic [7:0]  lcl_inum;
  logic        lcl_ordy, lcl_dv, lcl_olast;
  logic [63:0] lcl_dout;
  logic [5:0]  status;
  logic [3:0]  error;

  always #5 clk = ~clk;

  axi_master_rd dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .i_snap_context(i_snap_context),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .lcl_ibusy(lcl_ibusy), .lcl_istart(lcl_istart), .lcl_iaddr(lcl_iaddr), .lcl_inum(lcl_inum),
    .lcl_ordy(lcl_ordy), .lcl_dv(lcl_dv), .lcl_dout(lcl_dout), .lcl_olast(lcl_olast),
    .status(status), .error(error)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  inum;
    int          n_send;
    int          rlast_idx;
    int          resp_idx;
    logic [1:0]  resp_val;
    logic [7:0]  exp_arlen;
    int          exp_out;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [64:0] got_q[$];

  // Local sink: record every beat that pops (sampled mid-cycle)
  always @(negedge clk) begin
    if (rst_n && lcl_dv && lcl_ordy) got_q.push_back({lcl_olast, lcl_dout});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [1:0] resp);
    int n = 0;
    bit ok = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = d;
    m_axi_rlast  = last;
    m_axi_rresp  = resp;
    while (n < 200) begin
      @(negedge clk);
      if (m_axi_rready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    check("rready_wait", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic start_burst(input logic [63:0] addr, input logic [7:0] inum,
                             input logic [7:0] exp_arlen);
    lcl_iaddr  = addr;
    lcl_inum   = inum;
    lcl_istart = 1'b1;
    tick();
    lcl_istart = 1'b0;
    check("arvalid_set", 64'(m_axi_arvalid), 64'(1));
    check("araddr", m_axi_araddr, addr);
    check("arlen", 64'(m_axi_arlen), 64'(exp_arlen));
    check("aruser", 64'(m_axi_aruser), 64'h5A);
    check("busy_set", 64'(lcl_ibusy), 64'(1));
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    check("arvalid_clr", 64'(m_axi_arvalid), 64'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (lcl_ibusy && n < 1000) begin
      tick();
      n++;
    end
    check("busy_clr", 64'(lcl_ibusy), 64'(0));
    tick();
  endtask

  task automatic check_out(input logic [63:0] base, input int exp_n);
    check("out_count", 64'(got_q.size()), 64'(exp_n));
    for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
      check($sformatf("out_data[%0d]", i), got_q[i][63:0], base + 64'(i));
      check($sformatf("out_last[%0d]", i), 64'(got_q[i][64]), 64'(i == exp_n - 1));
    end
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'(0));
    check({tag, "_araddr"}, m_axi_araddr, 64'(0));
    check({tag, "_arlen"}, 64'(m_axi_arlen), 64'(0));
    check({tag, "_rready"}, 64'(m_axi_rready), 64'(0));
    check({tag, "_dv"}, 64'(lcl_dv), 64'(0));
    check({tag, "_olast"}, 64'(lcl_olast), 64'(0));
    check({tag, "_busy"}, 64'(lcl_ibusy), 64'(0));
    check({tag, "_status"}, 64'(status), 64'h10);
    check({tag, "_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    //        addr          inum  send rlast resp rv     arlen out  err
    vecs[0] = '{64'h1000,  8'd4,   4,   3,  -1, 2'b00, 8'd3,   4, 4'b0000};
    vecs[1] = '{64'h2000,  8'd1,   1,   0,  -1, 2'b00, 8'd0,   1, 4'b0000};
    vecs[2] = '{64'h3000,  8'd4,   4,   3,   1, 2'b10, 8'd3,   4, 4'b0010};
    vecs[3] = '{64'h4000,  8'd8,   5,   4,  -1, 2'b00, 8'd7,   5, 4'b1000};
    vecs[4] = '{64'h5000,  8'd4,   5,   4,  -1, 2'b00, 8'd3,   4, 4'b0100};
    vecs[5] = '{64'h6000,  8'd0, 256, 255, 255, 2'b01, 8'd255, 256, 4'b0001};

    rst_n = 1'b0; clear = 1'b0; i_snap_context = 32'hABCD_EF5A;
    m_axi_arready = 1'b0; m_axi_rid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    lcl_istart = 1'b0; lcl_iaddr = '0; lcl_inum = '0; lcl_ordy = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check("idle_rready", 64'(m_axi_rready), 64'(1));
    check("arsize", 64'(m_axi_arsize), 64'(3));
    check("arburst", 64'(m_axi_arburst), 64'(1));
    check("arcache", 64'(m_axi_arcache), 64'(3));
    check("ar_zero", 64'({m_axi_arid, m_axi_arlock, m_axi_arprot, m_axi_arqos, m_axi_arregion}), 64'(0));

    // Table of bursts with full local throughput
    for (int i = 0; i < 6; i++) begin
      lcl_ordy = 1'b1;
      got_q.delete();
      start_burst(vecs[i].addr, vecs[i].inum, vecs[i].exp_arlen);
      for (int b = 0; b < vecs[i].n_send; b++)
        send_beat(vecs[i].addr + 64'(b), b == vecs[i].rlast_idx,
                  (b == vecs[i].resp_idx) ? vecs[i].resp_val : 2'b00);
      wait_idle();
      check_out(vecs[i].addr, vecs[i].exp_out);
      check($sformatf("v%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_st_err", i), 64'(status[3:0]),
            64'({|vecs[i].exp_err[3:2], 1'b0, vecs[i].exp_err[1:0]}));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check($sformatf("v%0d_cleared", i), 64'(error), 64'(0));
    end

    // Backpressure: FIFO fills at 16 beats, rready drops, then drains without loss
    lcl_ordy = 1'b0;
    got_q.delete();
    start_burst(64'h7000, 8'd32, 8'd31);
    for (int b = 0; b < 16; b++) send_beat(64'h7000 + 64'(b), 1'b0, 2'b00);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 64'h7010;
    tick();
    tick();
    check("bp_rready", 64'(m_axi_rready), 64'(0));
    check("bp_full", 64'(status[5]), 64'(1));
    check("bp_head", lcl_dout, 64'h7000);
    lcl_ordy = 1'b1;
    for (int b = 16; b < 32; b++) send_beat(64'h7000 + 64'(b), b == 31, 2'b00);
    wait_idle();
    check_out(64'h7000, 32);
    check("bp_error", 64'(error), 64'(0));

    // Start strobe while busy is ignored
    start_burst(64'h8000, 8'd2, 8'd1);
    lcl_iaddr  = 64'h9000;
    lcl_istart = 1'b1;
    tick();
    lcl_istart = 1'b0;
    check("busy_ign_arvalid", 64'(m_axi_arvalid), 64'(0));
    check("busy_ign_araddr", m_axi_araddr, 64'h8000);
    for (int b = 0; b < 2; b++) send_beat(64'h8000 + 64'(b), b == 1, 2'b00);
    wait_idle();
    check("busy_ign_no_ar", 64'(m_axi_arvalid), 64'(0));
    check_out(64'h8000, 2);

    // Reset in the middle of the data phase
    lcl_ordy = 1'b0;
    start_burst(64'hA000, 8'd8, 8'd7);
    for (int b = 0; b < 3; b++) send_beat(64'hA000 + 64'(b), 1'b0, 2'b11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    got_q.delete();
    lcl_ordy = 1'b1;
    tick();
    start_burst(64'hB000, 8'd3, 8'd2);
    for (int b = 0; b < 3; b++) send_beat(64'hB000 + 64'(b), b == 2, 2'b00);
    wait_idle();
    check_out(64'hB000, 3);
    check("post_rst_error", 64'(error), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
